wb_arbiter_2to1: RTL
====================

// Module: wb_arbiter_2to1
// PURPOSE
//  Shares one pipelined Wishbone peripheral bus between two controllers: CPU instruction port (m0) and
//  CPU data port (m1). Sits in the SoC shared interconnect, between cpu.instr_wb/data_wb and a single
//  memory/peripheral decoder. Grants whole bus cycles (CYC-held), tracks outstanding pipelined requests,
//  and aborts hung transfers with a watchdog error.
// PARAMETERS
//  ROUND_ROBIN      1     1: alternate priority after each grant; 0: fixed priority, m1 (data) wins ties
//  MAX_OUTSTANDING  8     max in-flight STB-accepted requests per cycle; counter width $clog2(MAX+1)
//  TIMEOUT_CYCLES   1024  cycles with outstanding>0 and no ACK/ERR before forced error; 0 disables
// PORTS
//  i_clk      in   1     clock
//  i_rst_n    in   1     asynchronous active-low reset
//  m0_wb      in   intf  Wishbone.Peripheral, instruction controller side
//  m1_wb      in   intf  Wishbone.Peripheral, data controller side
//  s_wb       out  intf  Wishbone.Controller, to shared peripheral
//  o_grant    out  2     one-hot current owner (debug), 2'b00 when idle
//  o_timeout  out  1     one-cycle pulse when watchdog fires
//  Interface signals: cyc, stb, we, adr[31:0], dat_w[31:0], sel[3:0] (ctl->per); dat_r[31:0], ack, err, stall (per->ctl)
// BEHAVIOUR
//  Reset (async assert, sync deassert on i_clk): state=IDLE, o_grant=0, outstanding=0, rr_last=m1,
//   o_timeout=0; s_wb.cyc/stb/we=0; m0/m1 ack=err=0, stall=1.
//  FSM states IDLE, OWN_M0, OWN_M1 (enum in package).
//   IDLE: if any mX.cyc, register grant to winner at next edge; zero-cycle grant forbidden, so first
//    STB is forwarded no earlier than 1 cycle after CYC rises. Both request: ROUND_ROBIN ? not rr_last : m1.
//   OWN_Mx: s_wb.{cyc,stb,we,adr,dat_w,sel} = mX combinationally; mX.{ack,err,stall,dat_r} = s_wb.
//    Losing master: stall=1, ack=0, err=0, dat_r=0. Ownership never preempted mid-cycle.
//   Release: mX.cyc low -> IDLE next edge, rr_last<=X; s_wb.cyc follows mX.cyc same cycle (abort semantics).
//    Back-to-back: other master waiting at release gets grant on the following edge (1 idle bus cycle).
//  Outstanding counter: +1 on s_wb.stb & ~s_wb.stall, -1 on s_wb.ack|s_wb.err; both same cycle -> unchanged.
//   At MAX_OUTSTANDING the arbiter forces owner stall=1 and gates s_wb.stb=0 until a response returns.
//   Clears to 0 on release. Underflow (response with count 0) ignored, count stays 0.
//   ACK/ERR arriving in IDLE (stray, after abort) dropped; never routed to any master.
//  Watchdog: counter resets on any response or when outstanding==0; at TIMEOUT_CYCLES-1 with
//   outstanding>0: pulse o_timeout, drive owner err=1 for 1 cycle, force s_wb.cyc=0 that cycle,
//   clear outstanding, return to IDLE; owner must restart its bus cycle.
//  Reset mid-cycle: all outputs to reset values immediately (async), in-flight responses discarded.
//  Widths: dat/adr pass-through unmodified; no address decode in this block.
// STRUCTURE
//  wb_pkg: arb_state_t {IDLE,OWN_M0,OWN_M1}, WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
//  Sub-module wb_outstanding_tracker: counter + watchdog (inputs req_accept, resp, clear; outputs
//   count_full, count_zero, timeout). Arbiter top holds FSM, rr_last, and muxes.
// TESTING
//  1 m0 cyc+stb read adr 0x10000004, slave ack after 3 cycles -> o_grant=01 after 1 edge, m0 gets dat_r, m1 stall=1.
//  2 m0,m1 raise cyc same edge, ROUND_ROBIN=1, rr_last=m1 -> m0 first; after m0 cyc drop, m1 granted next edge.
//  3 m1 issues 8 pipelined stb with slave stall=0, no ack -> 9th stb stalled, s_wb.stb=0 until first ack.
//  4 TIMEOUT_CYCLES=16, slave never acks 1 request -> on cycle 16 o_timeout=1, m1.err=1, state IDLE, s_wb.cyc=0.
//  5 m0 drops cyc with 2 outstanding, slave acks 2 cycles later -> acks dropped, neither master sees ack.
//  6 i_rst_n low mid-burst -> s_wb.cyc=0, o_grant=0 same cycle; after release bus idle until new cyc.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths and arbiter state encoding for the 2:1 interconnect arbiter.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } arb_state_t;

    // One-hot owner vector; zero while the bus is idle.
    function automatic logic [1:0] grant_of(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == OWN_M0) g = 2'b01;
        if (s == OWN_M1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/wb_outstanding_tracker.sv
// Counts accepted-but-unanswered requests and raises a timeout when responses stop arriving.
module wb_outstanding_tracker #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic req_accept,
    input  logic resp,
    input  logic clear,
    output logic count_full,
    output logic count_zero,
    output logic timeout
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             dec;

    assign count_zero = (count_reg == '0);
    assign count_full = (count_reg == CNT_W'(MAX_OUTSTANDING));
    // A response with nothing outstanding must not wrap the counter.
    assign dec        = resp & ~count_zero;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (req_accept && !dec) begin
            count_next = count_reg + CNT_W'(1);
        end else if (dec && !req_accept) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_wd
        localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
        logic [WD_W-1:0] wd_reg;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                wd_reg <= '0;
            end else if (clear || count_zero || resp) begin
                wd_reg <= '0;
            end else begin
                wd_reg <= wd_reg + WD_W'(1);
            end
        end

        assign timeout = ~count_zero & ~resp & (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wd
        assign timeout = 1'b0;
    end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-controller pipelined Wishbone arbiter: whole-cycle grants, outstanding limit, watchdog abort.
module wb_arbiter_2to1
    import wb_pkg::*;
#(
    parameter int ROUND_ROBIN     = 1,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                m0_cyc,
    input  logic                m0_stb,
    input  logic                m0_we,
    input  logic [WB_ADR_W-1:0] m0_adr,
    input  logic [WB_DAT_W-1:0] m0_dat_w,
    input  logic [WB_SEL_W-1:0] m0_sel,
    output logic [WB_DAT_W-1:0] m0_dat_r,
    output logic                m0_ack,
    output logic                m0_err,
    output logic                m0_stall,
    input  logic                m1_cyc,
    input  logic                m1_stb,
    input  logic                m1_we,
    input  logic [WB_ADR_W-1:0] m1_adr,
    input  logic [WB_DAT_W-1:0] m1_dat_w,
    input  logic [WB_SEL_W-1:0] m1_sel,
    output logic [WB_DAT_W-1:0] m1_dat_r,
    output logic                m1_ack,
    output logic                m1_err,
    output logic                m1_stall,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [WB_ADR_W-1:0] s_adr,
    output logic [WB_DAT_W-1:0] s_dat_w,
    output logic [WB_SEL_W-1:0] s_sel,
    input  logic [WB_DAT_W-1:0] s_dat_r,
    input  logic                s_ack,
    input  logic                s_err,
    input  logic                s_stall,
    output logic [1:0]          o_grant,
    output logic                o_timeout
);

    arb_state_t state_reg, state_next;
    logic       rr_last_reg, rr_last_next;    // 1 = m1 was the last owner

    logic [1:0] grant;
    logic       owned, sel_m1;
    logic       own_cyc, own_stb, own_we;
    logic [WB_ADR_W-1:0] own_adr;
    logic [WB_DAT_W-1:0] own_dat_w;
    logic [WB_SEL_W-1:0] own_sel;
    logic       count_full, count_zero, timeout;
    logic       req_accept, resp, clear;

    assign grant  = grant_of(state_reg);
    assign owned  = (state_reg != IDLE);
    assign sel_m1 = (state_reg == OWN_M1);

    assign own_cyc   = sel_m1 ? m1_cyc   : m0_cyc;
    assign own_stb   = sel_m1 ? m1_stb   : m0_stb;
    assign own_we    = sel_m1 ? m1_we    : m0_we;
    assign own_adr   = sel_m1 ? m1_adr   : m0_adr;
    assign own_dat_w = sel_m1 ? m1_dat_w : m0_dat_w;
    assign own_sel   = sel_m1 ? m1_sel   : m0_sel;

    // The watchdog abort drops CYC in the same cycle the error is reported.
    assign s_cyc   = owned & own_cyc & ~timeout;
    assign s_stb   = owned & own_stb & ~count_full & ~timeout;
    assign s_we    = owned & own_we;
    assign s_adr   = owned ? own_adr   : '0;
    assign s_dat_w = owned ? own_dat_w : '0;
    assign s_sel   = owned ? own_sel   : '0;

    assign req_accept = s_stb & ~s_stall;
    assign resp       = owned & (s_ack | s_err) & ~count_zero;
    assign clear      = owned & (~own_cyc | timeout);

    wb_outstanding_tracker #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tracker (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .req_accept(req_accept),
        .resp      (resp),
        .clear     (clear),
        .count_full(count_full),
        .count_zero(count_zero),
        .timeout   (timeout)
    );

    logic [1:0]          m_ack, m_err, m_stall;
    logic [WB_DAT_W-1:0] m_dat_r [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign m_ack[gi]   = grant[gi] & s_ack;
        assign m_err[gi]   = grant[gi] & (s_err | timeout);
        assign m_stall[gi] = ~grant[gi] | s_stall | count_full;
        assign m_dat_r[gi] = grant[gi] ? s_dat_r : '0;
    end

    assign m0_ack   = m_ack[0];
    assign m0_err   = m_err[0];
    assign m0_stall = m_stall[0];
    assign m0_dat_r = m_dat_r[0];
    assign m1_ack   = m_ack[1];
    assign m1_err   = m_err[1];
    assign m1_stall = m_stall[1];
    assign m1_dat_r = m_dat_r[1];

    assign o_grant   = grant;
    assign o_timeout = timeout;

    always_comb begin
        state_next   = state_reg;
        rr_last_next = rr_last_reg;
        case (state_reg)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    if (ROUND_ROBIN != 0) state_next = rr_last_reg ? OWN_M0 : OWN_M1;
                    else                  state_next = OWN_M1;
                end else if (m0_cyc) begin
                    state_next = OWN_M0;
                end else if (m1_cyc) begin
                    state_next = OWN_M1;
                end
            end
            OWN_M0, OWN_M1: begin
                if (clear) begin
                    state_next   = IDLE;
                    rr_last_next = sel_m1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            rr_last_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            rr_last_reg <= rr_last_next;
        end
    end

endmodule
